// File: rtl/pid_output_router.sv
// Steers the single PID result stream into per-destination FWFT FIFOs, each with its own
// overflow policy, saturating overflow counter and fill level.
module pid_output_router #(
  parameter int N_DEST    = 8,
  parameter int W_CHAN    = 5,
  parameter int W_DATA    = 48,
  parameter int CHAN_BASE = 0,
  parameter int DEPTH     = 4,
  parameter int W_OVF     = 16,
  localparam int W_PTR    = $clog2(DEPTH),
  localparam int W_FILL   = W_PTR + 1
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       dv_in,
  input  logic [W_CHAN-1:0]          chan_in,
  input  logic [W_DATA-1:0]          data_in,
  input  logic [N_DEST-1:0]          mode_in,
  input  logic                       ovf_clr_in,
  input  logic [N_DEST-1:0]          done_in,
  output logic [N_DEST-1:0]          dv_out,
  output logic [N_DEST*W_DATA-1:0]   data_out,
  output logic [N_DEST*W_FILL-1:0]   fill_out,
  output logic [N_DEST*W_OVF-1:0]    ovf_cnt_out,
  output logic                       unmap_out
);

  logic [32:0] chan_off_s;
  logic [31:0] dest_idx_s;
  logic        map_ok_s;
  logic        unmap_r;

  // Channel-to-destination mapping; the borrow bit flags channels below the base.
  always_comb begin
    chan_off_s = {1'b0, 32'(chan_in)} - {1'b0, 32'(CHAN_BASE)};
    dest_idx_s = chan_off_s[31:0];
    map_ok_s   = !chan_off_s[32] && (dest_idx_s < 32'(N_DEST));
  end

  // One-cycle flag for words that land outside the mapped channel range.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      unmap_r <= 1'b0;
    end else begin
      unmap_r <= dv_in && !map_ok_s;
    end
  end

  assign unmap_out = unmap_r;

  for (genvar d = 0; d < N_DEST; d++) begin : g_dest
    logic [W_DATA-1:0] mem_r [DEPTH];
    logic [W_PTR-1:0]  rd_ptr_r;
    logic [W_PTR-1:0]  wr_ptr_r;
    logic [W_FILL-1:0] fill_r;
    logic [W_FILL-1:0] fill_nxt_s;
    logic [W_OVF-1:0]  ovf_cnt_r;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              ovf_s;
    logic              wr_en_s;
    logic              rd_adv_s;
    logic              head_vld_s;

    // Push/pop decode; an overwrite-mode overflow behaves like a simultaneous push and pop.
    always_comb begin
      head_vld_s = (fill_r != {W_FILL{1'b0}});
      push_s     = dv_in && map_ok_s && (dest_idx_s == 32'(d));
      pop_s      = done_in[d] && head_vld_s;
      full_s     = (fill_r == W_FILL'(DEPTH));
      ovf_s      = push_s && full_s && !pop_s;
      wr_en_s    = push_s && (!ovf_s || mode_in[d]);
      rd_adv_s   = pop_s || (ovf_s && mode_in[d]);
      if (wr_en_s && !rd_adv_s) begin
        fill_nxt_s = fill_r + W_FILL'(1);
      end else if (rd_adv_s && !wr_en_s) begin
        fill_nxt_s = fill_r - W_FILL'(1);
      end else begin
        fill_nxt_s = fill_r;
      end
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        rd_ptr_r <= {W_PTR{1'b0}};
        wr_ptr_r <= {W_PTR{1'b0}};
        fill_r   <= {W_FILL{1'b0}};
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + W_PTR'(1);
        end
        if (rd_adv_s) begin
          rd_ptr_r <= rd_ptr_r + W_PTR'(1);
        end
        fill_r <= fill_nxt_s;
      end
    end

    // Word storage; contents need no reset because fill gates visibility.
    always_ff @(posedge clk_in) begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= data_in;
      end
    end

    // Saturating overflow counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        ovf_cnt_r <= {W_OVF{1'b0}};
      end else if (ovf_clr_in) begin
        ovf_cnt_r <= {W_OVF{1'b0}};
      end else if (ovf_s && (ovf_cnt_r != {W_OVF{1'b1}})) begin
        ovf_cnt_r <= ovf_cnt_r + W_OVF'(1);
      end
    end

    assign dv_out[d]                        = head_vld_s;
    assign data_out[d*W_DATA +: W_DATA]     = head_vld_s ? mem_r[rd_ptr_r] : {W_DATA{1'b0}};
    assign fill_out[d*W_FILL +: W_FILL]     = fill_r;
    assign ovf_cnt_out[d*W_OVF +: W_OVF]    = ovf_cnt_r;
  end

endmodule
